// File: rtl/reg_file_2r1w.sv
// ---------------------------------------------------------------------------
// reg_file_2r1w
// Operand-fetch register bank: two combinational read ports, one synchronous
// write port. The storage array has no reset. After reset, or on clr_req,
// a sequential sweep zeroes the array one entry per cycle. Reads return 0 and
// writes are refused while the sweep runs.
//
// Parameters
//   DATA_W   : entry width
//   ADDR_W   : address width, DEPTH = 2**ADDR_W
//   ZERO_REG : 1 = entry 0 reads as zero and ignores writes
//   BYPASS   : 1 = same-cycle accepted write is forwarded to a matching read
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data : write request; accepted when wr_rdy is high
//   wr_rdy                : write accepted this cycle (not busy)
//   rd_addr_a/rd_data_a   : read port A, zero-latency
//   rd_addr_b/rd_data_b   : read port B, zero-latency
//   clr_req               : single-cycle request to zero the whole array
//   busy                  : clear sweep in progress
// ---------------------------------------------------------------------------
module reg_file_2r1w #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_rdy,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              clr_req,
    output logic              busy
);

    localparam int unsigned       DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              wr_rdy_q, wr_rdy_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Next-state logic for the clear sweep
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        if (rst) begin
            state_d = ST_CLEAR;
            idx_d   = '0;
            busy_d  = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (clr_req) begin
                        state_d = ST_CLEAR;
                        idx_d   = '0;
                        busy_d  = 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // Last entry ends the sweep; idx parks at 0 instead of wrapping on
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            endcase
        end
        wr_rdy_d = ~busy_d;
    end

    // FSM and status flops
    always_ff @(posedge clk) begin
        state_q  <= state_d;
        idx_q    <= idx_d;
        busy_q   <= busy_d;
        wr_rdy_q <= wr_rdy_d;
    end

    // Single write port shared between the sweep and the user write
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (busy_q) begin
            // Sweep pauses while rst holds idx at 0
            if (!rst) begin
                mem_we    = 1'b1;
                mem_waddr = idx_q;
                mem_wdata = '0;
            end
        end else if (wr_en && !(ZERO_REG && (wr_addr == '0))) begin
            mem_we = 1'b1;
        end
    end

    // Storage array, intentionally without reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Read port A
    always_comb begin
        rd_data_a = mem_q[rd_addr_a];
        if (busy_q) begin
            rd_data_a = '0;
        end else if (ZERO_REG && (rd_addr_a == '0)) begin
            rd_data_a = '0;
        end else if (BYPASS && wr_en && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end
    end

    // Read port B
    always_comb begin
        rd_data_b = mem_q[rd_addr_b];
        if (busy_q) begin
            rd_data_b = '0;
        end else if (ZERO_REG && (rd_addr_b == '0)) begin
            rd_data_b = '0;
        end else if (BYPASS && wr_en && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end
    end

    assign busy   = busy_q;
    assign wr_rdy = wr_rdy_q;

endmodule
